// File: rtl/fir_coef_loader_pkg.sv
// Shared FIR definitions: loader FSM encoding and default datapath sizing.
package fir_coef_loader_pkg;

  localparam int unsigned NTAPS_DEF      = 21;
  localparam int unsigned COEF_W_DEF     = 16;
  localparam int unsigned SETTLE_CYC_DEF = 21;
  localparam int unsigned LOAD_CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } fir_state_t;

  // Settle counter width; a zero-length settle still needs a 1-bit counter.
  function automatic int unsigned settle_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_coef_loader_if.sv
// Valid/ready coefficient stream feeding the loader.
interface fir_coef_loader_if
  import fir_coef_loader_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF
) ();

  logic [COEF_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/fir_coef_loader.sv
// Loads NTAPS coefficients into the FIR coefficient chain, then holds mute
// for one delay-line flush before reporting completion.
module fir_coef_loader
  import fir_coef_loader_pkg::*;
#(
  parameter int unsigned NTAPS      = NTAPS_DEF,
  parameter int unsigned COEF_W     = COEF_W_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  fir_coef_loader_if.slave      s,
  output logic [COEF_W-1:0]     coef_out,
  output logic                  coef_shift,
  output logic                  mute,
  output logic                  busy,
  output logic [LOAD_CNT_W-1:0] load_count,
  output logic                  done,
  output logic                  aborted
);

  localparam int unsigned          SW          = settle_w(SETTLE_CYC);
  localparam logic [LOAD_CNT_W-1:0] NTAPS_CNT  = LOAD_CNT_W'(NTAPS);
  localparam logic [LOAD_CNT_W-1:0] LAST_CNT   = LOAD_CNT_W'(NTAPS - 1);
  localparam logic [SW-1:0]         SETTLE_LAST =
    SW'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  fir_state_t              state_q, state_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [COEF_W-1:0]       coef_d;
  logic                    shift_d, mute_d, busy_d, done_d, aborted_d;
  logic [LOAD_CNT_W-1:0]   cnt_d;
  logic                    xfer;

  assign s.s_ready = (state_q == ST_LOAD);
  assign xfer      = s.s_valid && (state_q == ST_LOAD);

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    coef_d    = coef_out;
    shift_d   = 1'b0;
    cnt_d     = load_count;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          // A word arriving with abort is dropped, not shifted or counted.
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (xfer) begin
          shift_d = 1'b1;
          coef_d  = s.s_data;
          if (load_count < NTAPS_CNT) cnt_d = load_count + LOAD_CNT_W'(1);
          if (load_count >= LAST_CNT) begin
            settle_d = '0;
            state_d  = (SETTLE_CYC == 0) ? ST_DONE : ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_DONE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_SETTLE);
    mute_d = busy_d;
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      coef_out   <= '0;
      coef_shift <= 1'b0;
      mute       <= 1'b0;
      busy       <= 1'b0;
      load_count <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      coef_out   <= coef_d;
      coef_shift <= shift_d;
      mute       <= mute_d;
      busy       <= busy_d;
      load_count <= cnt_d;
      done       <= done_d;
      aborted    <= aborted_d;
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed self-checking bench for the FIR coefficient loader.
module tb_fir_coef_loader;
  import fir_coef_loader_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  start, abort;
  logic [15:0]           coef_out;
  logic                  coef_shift, mute, busy, done, aborted;
  logic [LOAD_CNT_W-1:0] load_count;

  int passed = 0;
  int total  = 0;

  fir_coef_loader_if #(.COEF_W(16)) bus ();

  fir_coef_loader #(.NTAPS(21), .COEF_W(16), .SETTLE_CYC(21)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .s          (bus),
    .coef_out   (coef_out),
    .coef_shift (coef_shift),
    .mute       (mute),
    .busy       (busy),
    .load_count (load_count),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until done rises, or -1 if it never does within maxc.
  task automatic wait_done(input int maxc, output int n, output int extra_shifts);
    n = -1;
    extra_shifts = 0;
    for (int k = 1; k <= maxc; k++) begin
      tick();
      extra_shifts += int'(coef_shift);
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_coef_out"}, 32'(coef_out), 0);
    chk({tag, "_shift"},    32'(coef_shift), 0);
    chk({tag, "_mute"},     32'(mute), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_count"},    32'(load_count), 0);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_aborted"},  32'(aborted), 0);
    chk({tag, "_ready"},    32'(bus.s_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, extra, shifts, acc;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    #12;
    check_all_zero("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // Back-to-back load of 0x0001..0x0015.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t44_busy", 32'(busy), 1);
    chk("t44_mute", 32'(mute), 1);
    chk("t44_ready", 32'(bus.s_ready), 1);
    chk("t44_count0", 32'(load_count), 0);
    shifts = 0;
    for (int i = 1; i <= 21; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(i);
      tick();
      shifts += int'(coef_shift);
      chk("t44_shift", 32'(coef_shift), 1);
      chk("t44_coef", 32'(coef_out), 32'(i));
    end
    bus.s_valid = 1'b0;
    chk("t44_shifts", 32'(shifts), 21);
    chk("t44_count", 32'(load_count), 21);
    chk("t44_ready_settle", 32'(bus.s_ready), 0);
    chk("t44_mute_settle", 32'(mute), 1);
    wait_done(40, n, extra);
    chk("t44_done_lat", 32'(n), 21);
    chk("t44_no_extra_shift", 32'(extra), 0);
    chk("t44_done_mute", 32'(mute), 0);
    chk("t44_done_busy", 32'(busy), 0);
    chk("t44_coef_hold", 32'(coef_out), 32'h15);
    tick();
    chk("t44_done_pulse", 32'(done), 0);
    chk("t44_idle_mute", 32'(mute), 0);

    // s_valid toggling every cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    acc = 0;
    shifts = 0;
    for (int c = 0; c < 60 && acc < 21; c++) begin
      bus.s_valid = ((c % 2) == 0);
      bus.s_data  = 16'(32'h100 + acc);
      chk("t45_ready", 32'(bus.s_ready), 1);
      tick();
      shifts += int'(coef_shift);
      if ((c % 2) == 0) begin
        chk("t45_shift", 32'(coef_shift), 1);
        chk("t45_coef", 32'(coef_out), 32'h100 + 32'(acc));
        acc++;
      end else begin
        chk("t45_gap_shift", 32'(coef_shift), 0);
      end
    end
    bus.s_valid = 1'b0;
    chk("t45_shifts", 32'(shifts), 21);
    chk("t45_count", 32'(load_count), 21);
    chk("t45_ready_settle", 32'(bus.s_ready), 0);
    wait_done(40, n, extra);
    chk("t45_done_lat", 32'(n), 21);
    tick();

    // Abort after 10 words, coinciding with an 11th offered word.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(32'h300 + i);
      tick();
    end
    bus.s_data = 16'hBEEF;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.s_valid = 1'b0;
    chk("t46_aborted", 32'(aborted), 1);
    chk("t46_shift", 32'(coef_shift), 0);
    chk("t46_coef", 32'(coef_out), 32'h30A);
    chk("t46_count", 32'(load_count), 10);
    chk("t46_done", 32'(done), 0);
    chk("t46_ready", 32'(bus.s_ready), 0);
    chk("t46_mute", 32'(mute), 0);
    chk("t46_busy", 32'(busy), 0);
    tick();
    chk("t46_aborted_pulse", 32'(aborted), 0);
    chk("t46_count_hold", 32'(load_count), 10);

    // start and abort together in IDLE; abort alone in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t47_busy", 32'(busy), 0);
    chk("t47_mute", 32'(mute), 0);
    chk("t47_ready", 32'(bus.s_ready), 0);
    chk("t47_aborted", 32'(aborted), 0);
    chk("t47_done", 32'(done), 0);
    chk("t47_count_hold", 32'(load_count), 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t47_idle_abort", 32'(aborted), 0);

    // Asynchronous reset during SETTLE.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(32'h400 + i);
      tick();
    end
    bus.s_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t48_mute_pre", 32'(mute), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t48_async");
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done || aborted) break;
    end
    chk("t48_no_done", 32'(done), 0);
    chk("t48_no_aborted", 32'(aborted), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t48_count0", 32'(load_count), 0);
    chk("t48_busy", 32'(busy), 1);
    chk("t48_ready", 32'(bus.s_ready), 1);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0A5A;
    tick();
    bus.s_valid = 1'b0;
    chk("t48_count1", 32'(load_count), 1);
    chk("t48_coef", 32'(coef_out), 32'h0A5A);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t48_abort", 32'(aborted), 1);

    // Start during LOAD ignored; 22 words offered, 21 accepted.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(32'h200 + i);
      start = (i == 5);
      if (i == 22) chk("t49_ready22", 32'(bus.s_ready), 0);
      tick();
      start = 1'b0;
      if (i <= 21) begin
        chk("t49_shift", 32'(coef_shift), 1);
        chk("t49_count", 32'(load_count), 32'(i));
      end else begin
        chk("t49_no_shift22", 32'(coef_shift), 0);
        chk("t49_count_sat", 32'(load_count), 21);
        chk("t49_coef_hold", 32'(coef_out), 32'h215);
      end
    end
    bus.s_valid = 1'b0;
    wait_done(40, n, extra);
    chk("t49_done_lat", 32'(n), 20);
    chk("t49_count_final", 32'(load_count), 21);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
